alu_exec_ctrl: RTL and testbench
================================

Name: alu_exec_ctrl

Overview:
- Operand-supply and write-back stage wrapped around the combinational alu.
- Holds a small register file and a carry flag.
- Accepts one instruction at a time over a valid/ready handshake, then reads the two source registers and drives the alu operand, carry and opcode inputs.
- Captures ALU_Out/Carry_Out, writes the result to the destination register, and pulses a completion strobe.
- A host port loads and inspects registers while the block is idle.

Parameters:
DATA_WIDTH, ALU_INPUT_WIDTH (package), register and operand width; ALU_OUTPUT_WIDTH must equal it.
NUM_REGS, 8, number of registers; power of two, at least 2.
ADDR_WIDTH, $clog2(NUM_REGS), register index width (derived, not overridden).

Ports:
Clock  input  1  single clock, all state on rising edge
Reset  input  1  asynchronous, active-high
Instr_Valid  input  1  instruction present
Instr_Ready  output  1  block can accept an instruction
Instr_Op  input  aluop_t  operation
Instr_SrcA  input  ADDR_WIDTH  A operand register
Instr_SrcB  input  ADDR_WIDTH  B operand register
Instr_Dest  input  ADDR_WIDTH  destination register
Instr_UseCarry  input  1  1: Carry_In = carry flag
Host_We  input  1  host register write
Host_Addr  input  ADDR_WIDTH  host register index
Host_Wdata  input  DATA_WIDTH  host write data
Host_Rdata  output  DATA_WIDTH  combinational read of regfile[Host_Addr]
A_In  output  DATA_WIDTH  to alu
B_In  output  DATA_WIDTH  to alu
Carry_In  output  1  to alu
Opcode  output  aluop_t  to alu
ALU_Out  input  DATA_WIDTH  from alu
Carry_Out  input  1  from alu
Done  output  1  one-cycle completion pulse
Result  output  DATA_WIDTH  last written result
Carry_Flag  output  1  current carry flag

Behaviour:
- Clock and reset: one clock, Clock. Reset is asynchronous and active-high, named Reset.
- Reset state:
  - FSM to IDLE.
  - All registers, operand registers, Result and Carry_Flag cleared to 0.
  - Done=0, Instr_Ready=1.
  - Opcode=ADD_OP, A_In=B_In=0, Carry_In=0.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE.
  - IDLE: Instr_Ready=1. On Instr_Valid, latch Op/SrcA/SrcB/Dest/UseCarry and go to READ.
  - READ: opA <= reg[SrcA], opB <= reg[SrcB].
  - EXEC: A_In=opA, B_In=opB, Opcode=latched op; Carry_In per the rule below. Capture ALU_Out into res and Carry_Out into cres.
  - WB: reg[Dest] <= res; Result <= res; Done=1 for this cycle only.
    - ADD_OP/SUB_OP: Carry_Flag <= cres.
    - All logical ops: Carry_Flag unchanged.
- Carry_In rule:
  - UseCarry=1: Carry_In = Carry_Flag.
  - UseCarry=0: Carry_In = 1 for SUB_OP (two's complement subtract), else 0.
- Handshake and latency:
  - Instr_Ready=0 in READ, EXEC and WB. Instr_Valid is ignored there; the instruction is not queued.
  - Done asserts exactly 3 cycles after the accepting edge.
  - Minimum spacing between accepts is 4 cycles. A new instruction may be accepted on the cycle after WB.
- Register hazards:
  - Dest equal to SrcA or SrcB is legal; sources are read in READ, before WB.
  - SrcA equal to SrcB is legal.
- ALU ports outside EXEC: A_In, B_In and Opcode hold their last values; Carry_In is 0.
- Host port:
  - Host_We takes effect only in IDLE, and only when that cycle does not accept an instruction. Otherwise the write is dropped with no error.
  - Host_Rdata is valid in all states and reflects a WB write on the following cycle.
- Arithmetic:
  - Widths are fixed at DATA_WIDTH and wrap-around is modular.
  - The carry/borrow sense is whatever the alu produces. For SUB with Carry_In=1, Carry_Out=1 means no borrow.
- Reset mid-operation: returns to IDLE immediately. The pending write-back is lost, Done is not asserted, and Carry_Flag is cleared.

Test Plan:
- Basic ADD: host writes R1=0x0F, R2=0x01; instr ADD SrcA=1 SrcB=2 Dest=3 UseCarry=0 -> Done exactly 3 cycles after accept; R3=0x10, Result=0x10, Carry_Flag=0; Instr_Ready low for 3 cycles.
- Carry chain: R1=0xFF, R2=0x01, ADD into R4 -> R4=0x00, Carry_Flag=1. Then ADD R0+R0 with UseCarry=1 into R5 -> R5=0x01, Carry_Flag=0.
- Subtract with borrow: R1=0x05, R2=0x07; SUB into R6 with UseCarry=0 -> Carry_In=1 during EXEC; R6=0xFE, Carry_Flag=0. Reversed operands -> R6=0x02, Carry_Flag=1.
- Logical ops preserve flag: with Carry_Flag=1, issue EXNOR of 0xA5 and 0x0F into R1 -> R1=0x55, Carry_Flag stays 1. Issue NOTA of R1 into R1 -> R1=0xAA.
- Busy behaviour: hold Instr_Valid high continuously with distinct instructions -> accepts occur exactly every 4 cycles. Host_We during EXEC -> target register unchanged.
- Reset mid-operation: assert Reset asynchronously during EXEC of ADD into R7 (prior value 0x33) -> all outputs at reset values at once; no Done pulse; R7=0x00; Instr_Ready=1 after release.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - operand-supply / write-back controller wrapped around a combinational alu
package alu_pkg;
    localparam int ALU_INPUT_WIDTH  = 8;
    localparam int ALU_OUTPUT_WIDTH = 8;

    typedef enum logic [3:0] {
        ADD_OP   = 4'd0,
        SUB_OP   = 4'd1,
        AND_OP   = 4'd2,
        OR_OP    = 4'd3,
        XOR_OP   = 4'd4,
        NAND_OP  = 4'd5,
        NOR_OP   = 4'd6,
        EXNOR_OP = 4'd7,
        NOTA_OP  = 4'd8,
        NOTB_OP  = 4'd9
    } aluop_t;
endpackage

module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter  int DATA_WIDTH = ALU_INPUT_WIDTH,
    parameter  int NUM_REGS   = 8,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Instr_Valid,
    output logic                  Instr_Ready,
    input  aluop_t                Instr_Op,
    input  logic [ADDR_WIDTH-1:0] Instr_SrcA,
    input  logic [ADDR_WIDTH-1:0] Instr_SrcB,
    input  logic [ADDR_WIDTH-1:0] Instr_Dest,
    input  logic                  Instr_UseCarry,
    input  logic                  Host_We,
    input  logic [ADDR_WIDTH-1:0] Host_Addr,
    input  logic [DATA_WIDTH-1:0] Host_Wdata,
    output logic [DATA_WIDTH-1:0] Host_Rdata,
    output logic [DATA_WIDTH-1:0] A_In,
    output logic [DATA_WIDTH-1:0] B_In,
    output logic                  Carry_In,
    output aluop_t                Opcode,
    input  logic [DATA_WIDTH-1:0] ALU_Out,
    input  logic                  Carry_Out,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Carry_Flag
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    aluop_t                op_q, op_d;
    logic [ADDR_WIDTH-1:0] srca_q, srca_d, srcb_q, srcb_d, dest_q, dest_d;
    logic                  use_carry_q, use_carry_d;
    logic [DATA_WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
    aluop_t                opcode_q, opcode_d;
    logic                  carry_in_q, carry_in_d;
    logic [DATA_WIDTH-1:0] res_q, res_d, result_q, result_d;
    logic                  cres_q, cres_d;
    logic                  flag_q, flag_d;
    logic                  done_q, done_d;
    logic                  ready_q, ready_d;

    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        op_d        = op_q;
        srca_d      = srca_q;
        srcb_d      = srcb_q;
        dest_d      = dest_q;
        use_carry_d = use_carry_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        opcode_d    = opcode_q;
        carry_in_d  = 1'b0;
        res_d       = res_q;
        cres_d      = cres_q;
        result_d    = result_q;
        flag_d      = flag_q;
        done_d      = 1'b0;
        ready_d     = ready_q;
        case (state_q)
            IDLE: begin
                if (Instr_Valid) begin
                    op_d        = Instr_Op;
                    srca_d      = Instr_SrcA;
                    srcb_d      = Instr_SrcB;
                    dest_d      = Instr_Dest;
                    use_carry_d = Instr_UseCarry;
                    ready_d     = 1'b0;
                    state_d     = READ;
                end else if (Host_We) begin
                    regs_d[Host_Addr] = Host_Wdata;
                end
            end
            READ: begin
                // Operands land on the alu ports exactly as EXEC begins.
                opa_d      = regs_q[srca_q];
                opb_d      = regs_q[srcb_q];
                opcode_d   = op_q;
                carry_in_d = use_carry_q ? flag_q : (op_q == SUB_OP);
                state_d    = EXEC;
            end
            EXEC: begin
                res_d   = ALU_Out;
                cres_d  = Carry_Out;
                state_d = WB;
            end
            WB: begin
                regs_d[dest_q] = res_q;
                result_d       = res_q;
                if (op_q == ADD_OP || op_q == SUB_OP) begin
                    flag_d = cres_q;
                end
                done_d  = 1'b1;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            op_q        <= ADD_OP;
            srca_q      <= '0;
            srcb_q      <= '0;
            dest_q      <= '0;
            use_carry_q <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            opcode_q    <= ADD_OP;
            carry_in_q  <= 1'b0;
            res_q       <= '0;
            cres_q      <= 1'b0;
            result_q    <= '0;
            flag_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            op_q        <= op_d;
            srca_q      <= srca_d;
            srcb_q      <= srcb_d;
            dest_q      <= dest_d;
            use_carry_q <= use_carry_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            opcode_q    <= opcode_d;
            carry_in_q  <= carry_in_d;
            res_q       <= res_d;
            cres_q      <= cres_d;
            result_q    <= result_d;
            flag_q      <= flag_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    assign Instr_Ready = ready_q;
    assign Host_Rdata  = regs_q[Host_Addr];
    assign A_In        = opa_q;
    assign B_In        = opb_q;
    assign Carry_In    = carry_in_q;
    assign Opcode      = opcode_q;
    assign Done        = done_q;
    assign Result      = result_q;
    assign Carry_Flag  = flag_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb/tb_alu_exec_ctrl.sv - self-checking bench for alu_exec_ctrl with a behavioural alu and register model
module tb_alu_exec_ctrl;
    import alu_pkg::*;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_valid, instr_ready, instr_usecarry;
    aluop_t        instr_op;
    logic [AW-1:0] instr_srca, instr_srcb, instr_dest;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata, host_rdata;
    logic [DW-1:0] a_in, b_in, alu_out, result;
    logic          carry_in, carry_out, done, carry_flag;
    aluop_t        opcode;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] m_regs [8];
    logic          m_flag;

    always #5 clk = ~clk;

    alu_exec_ctrl dut (
        .Clock(clk), .Reset(rst),
        .Instr_Valid(instr_valid), .Instr_Ready(instr_ready), .Instr_Op(instr_op),
        .Instr_SrcA(instr_srca), .Instr_SrcB(instr_srcb), .Instr_Dest(instr_dest),
        .Instr_UseCarry(instr_usecarry),
        .Host_We(host_we), .Host_Addr(host_addr), .Host_Wdata(host_wdata), .Host_Rdata(host_rdata),
        .A_In(a_in), .B_In(b_in), .Carry_In(carry_in), .Opcode(opcode),
        .ALU_Out(alu_out), .Carry_Out(carry_out),
        .Done(done), .Result(result), .Carry_Flag(carry_flag)
    );

    function automatic logic [DW:0] alu_ref(aluop_t op, logic [DW-1:0] a, logic [DW-1:0] b, logic cin);
        logic [DW:0] r;
        case (op)
            ADD_OP:   r = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
            SUB_OP:   r = {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, cin};
            AND_OP:   r = {1'b0, a & b};
            OR_OP:    r = {1'b0, a | b};
            XOR_OP:   r = {1'b0, a ^ b};
            NAND_OP:  r = {1'b0, ~(a & b)};
            NOR_OP:   r = {1'b0, ~(a | b)};
            EXNOR_OP: r = {1'b0, ~(a ^ b)};
            NOTA_OP:  r = {1'b0, ~a};
            NOTB_OP:  r = {1'b0, ~b};
            default:  r = '0;
        endcase
        return r;
    endfunction

    always_comb {carry_out, alu_out} = alu_ref(opcode, a_in, b_in, carry_in);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic host_write(input int a, input logic [DW-1:0] d);
        @(negedge clk);
        host_we = 1'b1; host_addr = AW'(a); host_wdata = d;
        @(posedge clk);
        #1 host_we = 1'b0;
        m_regs[a] = d;
    endtask

    task automatic reg_check(input string tag, input int a);
        host_addr = AW'(a);
        #1 check(tag, 32'(host_rdata), 32'(m_regs[a]));
    endtask

    // Full protocol walk of one instruction, cycle by cycle from the accepting edge.
    task automatic issue(input aluop_t op, input int a, input int b, input int d, input bit uc);
        logic [DW:0] r;
        logic        cin;
        @(negedge clk);
        instr_op = op; instr_srca = AW'(a); instr_srcb = AW'(b); instr_dest = AW'(d);
        instr_usecarry = uc; instr_valid = 1'b1;
        check("ready_idle", 32'(instr_ready), 1);
        cin = uc ? m_flag : (op == SUB_OP);
        r   = alu_ref(op, m_regs[a], m_regs[b], cin);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        check("ready_read", 32'(instr_ready), 0);
        check("done_read", 32'(done), 0);
        @(negedge clk);
        check("ready_exec", 32'(instr_ready), 0);
        check("a_in_exec", 32'(a_in), 32'(m_regs[a]));
        check("b_in_exec", 32'(b_in), 32'(m_regs[b]));
        check("opcode_exec", 32'(opcode), 32'(op));
        check("carry_in_exec", 32'(carry_in), 32'(cin));
        @(negedge clk);
        check("ready_wb", 32'(instr_ready), 0);
        check("done_wb", 32'(done), 0);
        check("carry_in_wb", 32'(carry_in), 0);
        @(negedge clk);
        m_regs[d] = r[DW-1:0];
        if (op == ADD_OP || op == SUB_OP) m_flag = r[DW];
        check("done_pulse", 32'(done), 1);
        check("ready_after", 32'(instr_ready), 1);
        check("result", 32'(result), 32'(r[DW-1:0]));
        check("carry_flag", 32'(carry_flag), 32'(m_flag));
        reg_check("dest_reg", d);
        @(negedge clk);
        check("done_single", 32'(done), 0);
    endtask

    initial begin
        int accepts [$];
        int cyc;
        rst = 1'b1; instr_valid = 1'b0; instr_op = ADD_OP; instr_srca = '0; instr_srcb = '0;
        instr_dest = '0; instr_usecarry = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_flag = 1'b0;

        #12;
        check("rst_ready", 32'(instr_ready), 1);
        check("rst_done", 32'(done), 0);
        check("rst_opcode", 32'(opcode), 32'(ADD_OP));
        check("rst_a_in", 32'(a_in), 0);
        check("rst_b_in", 32'(b_in), 0);
        check("rst_carry_in", 32'(carry_in), 0);
        check("rst_result", 32'(result), 0);
        check("rst_flag", 32'(carry_flag), 0);
        for (int i = 0; i < 8; i++) reg_check("rst_reg", i);
        @(negedge clk);
        rst = 1'b0;

        host_write(1, 8'h0F); host_write(2, 8'h01);
        issue(ADD_OP, 1, 2, 3, 1'b0);
        check("add_result", 32'(result), 'h10);
        check("add_flag", 32'(carry_flag), 0);

        host_write(1, 8'hFF);
        issue(ADD_OP, 1, 2, 4, 1'b0);
        check("carry_result", 32'(result), 'h00);
        check("carry_set", 32'(carry_flag), 1);
        issue(ADD_OP, 0, 0, 5, 1'b1);
        check("carry_chain_result", 32'(result), 'h01);
        check("carry_chain_flag", 32'(carry_flag), 0);

        host_write(1, 8'h05); host_write(2, 8'h07);
        issue(SUB_OP, 1, 2, 6, 1'b0);
        check("sub_borrow_result", 32'(result), 'hFE);
        check("sub_borrow_flag", 32'(carry_flag), 0);
        issue(SUB_OP, 2, 1, 6, 1'b0);
        check("sub_result", 32'(result), 'h02);
        check("sub_flag", 32'(carry_flag), 1);

        host_write(1, 8'hA5); host_write(2, 8'h0F);
        issue(EXNOR_OP, 1, 2, 1, 1'b0);
        check("exnor_result", 32'(result), 'h55);
        check("exnor_flag_kept", 32'(carry_flag), 1);
        issue(NOTA_OP, 1, 1, 1, 1'b0);
        check("nota_result", 32'(result), 'hAA);

        // Valid held high with a fresh instruction every cycle.
        for (cyc = 0; cyc < 13; cyc++) begin
            @(negedge clk);
            instr_op = aluop_t'($urandom_range(0, 9));
            instr_srca = AW'($urandom); instr_srcb = AW'($urandom);
            instr_dest = AW'($urandom); instr_usecarry = 1'($urandom);
            instr_valid = 1'b1;
            if (instr_ready) begin
                logic [DW:0] r;
                logic        cin;
                accepts.push_back(cyc);
                cin = instr_usecarry ? m_flag : (instr_op == SUB_OP);
                r = alu_ref(instr_op, m_regs[instr_srca], m_regs[instr_srcb], cin);
                m_regs[instr_dest] = r[DW-1:0];
                if (instr_op == ADD_OP || instr_op == SUB_OP) m_flag = r[DW];
            end
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;
        check("busy_accept_count", 32'(accepts.size()), 4);
        for (int i = 0; i < accepts.size(); i++) check("busy_accept_cycle", 32'(accepts[i]), 32'(4 * i));
        repeat (5) @(negedge clk);
        check("busy_flag", 32'(carry_flag), 32'(m_flag));
        for (int i = 0; i < 8; i++) reg_check("busy_reg", i);

        // Host writes during an accept cycle and during EXEC must both be dropped.
        @(negedge clk);
        instr_op = XOR_OP; instr_srca = 3'd1; instr_srcb = 3'd2; instr_dest = 3'd3;
        instr_usecarry = 1'b0; instr_valid = 1'b1;
        host_we = 1'b1; host_addr = 3'd6; host_wdata = ~m_regs[6];
        @(posedge clk);
        #1 instr_valid = 1'b0; host_we = 1'b0;
        m_regs[3] = m_regs[1] ^ m_regs[2];
        @(negedge clk);
        @(negedge clk);
        host_we = 1'b1; host_addr = 3'd5; host_wdata = ~m_regs[5];
        @(posedge clk);
        #1 host_we = 1'b0;
        repeat (3) @(negedge clk);
        reg_check("host_we_accept_dropped", 6);
        reg_check("host_we_exec_dropped", 5);
        reg_check("host_during_busy_dest", 3);

        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 2) == 0) host_write($urandom_range(0, 7), DW'($urandom));
            issue(aluop_t'($urandom_range(0, 9)), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), 1'($urandom));
        end

        host_write(7, 8'h33);
        @(negedge clk);
        instr_op = ADD_OP; instr_srca = 3'd1; instr_srcb = 3'd2; instr_dest = 3'd7;
        instr_usecarry = 1'b0; instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_flag = 1'b0;
        check("mid_rst_ready", 32'(instr_ready), 1);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_opcode", 32'(opcode), 32'(ADD_OP));
        check("mid_rst_a_in", 32'(a_in), 0);
        check("mid_rst_carry_in", 32'(carry_in), 0);
        check("mid_rst_result", 32'(result), 0);
        check("mid_rst_flag", 32'(carry_flag), 0);
        reg_check("mid_rst_r7", 7);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_done", 32'(done), 0);
            check("post_rst_ready", 32'(instr_ready), 1);
        end
        reg_check("post_rst_r7", 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
